lab3_rr_arbiter_32: RTL and testbench
=====================================

LAB3_RR_ARBITER_32 -- requirements
Module: lab3_rr_arbiter_32

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter MAX_HOLD, default 16, SHALL set the maximum number of consecutive cycles a grant is held; legal range is 2..256.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 req  input  32  request vector; req[i] high means requester i wants the shared resource.
REQ-006 grant  output  32  one-hot grant vector; all zeros when no grant is active.
REQ-007 grant_idx  output  5  index of the current grantee, held when grant_vld is low.
REQ-008 grant_vld  output  1  high while a grant is active.
REQ-009 timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 The block SHALL keep a 5-bit round-robin pointer ptr that gives the first requester index to search from.
REQ-012 In IDLE with req != 0 at a clock edge, the block SHALL select the first i with req[i]=1, searching ptr, ptr+1, ... modulo 32, and SHALL enter GRANT.
REQ-013 On entering GRANT, grant_idx SHALL equal the selected i and grant_vld SHALL be 1, both visible one cycle after the sampling edge (latency 1).
REQ-014 In IDLE with req == 0, all state SHALL hold and grant_vld SHALL stay 0.
REQ-015 grant SHALL be the 5-to-32 decode of grant_idx, enabled by grant_vld: grant = grant_vld ? (1 << grant_idx) : 0.
REQ-016 In GRANT, a hold counter hold_cnt of width clog2(MAX_HOLD) SHALL increment once per cycle, starting at 0 on grant entry.
REQ-017 In GRANT with req[grant_idx]=0 at an edge (voluntary release), the block SHALL set grant_vld to 0, set ptr to grant_idx+1 modulo 32 (31 wraps to 0), and return to IDLE.
REQ-018 In GRANT with req[grant_idx]=1 and hold_cnt == MAX_HOLD-1 (forced release), the block SHALL take the same actions as REQ-017 and SHALL also pulse timeout high for exactly one cycle.
REQ-019 Changes to req[j] for j != grant_idx during GRANT SHALL be ignored until the FSM returns to IDLE.
REQ-020 There SHALL be at least one IDLE cycle, with grant_vld=0, between any two grants; back-to-back grants are not permitted.
REQ-021 If a requester drops its request on the same edge that forced release would occur, the release SHALL be treated as voluntary and timeout SHALL stay 0.
REQ-022 grant, grant_idx, grant_vld and timeout SHALL all derive from registered state; there SHALL be no combinational path from req to any output.

Reset
REQ-023 While rst_n=0 at an edge, the block SHALL set state=IDLE, ptr=0, hold_cnt=0, grant_idx=0, grant_vld=0 and timeout=0; as a result grant=0.
REQ-024 If reset occurs mid-GRANT, grant SHALL drop to zero at that edge, no timeout pulse SHALL be issued, and ptr SHALL return to 0.

Structure
REQ-025 Package lab3_arb_pkg SHALL hold N_REQ=32, IDX_W=5 and the IDLE/GRANT state encoding.
REQ-026 The grant one-hot output SHALL be produced by instantiating the existing Lab2_decoder_5x32 sub-module with port order (Dout, A, enable), driven by grant_idx and grant_vld.

Verification
REQ-027 Reset test: reset, then hold req=0 for 50 cycles -> grant=0, grant_vld=0 and timeout=0 throughout.
REQ-028 Single-requester test: req=32'h0000_0001 -> one cycle later grant=32'h1, grant_idx=0, grant_vld=1; set req=0 -> grant=0 on the next cycle.
REQ-029 Timeout and wrap-around test: MAX_HOLD=4, req=32'h8000_0001 held -> grant[0] for 4 cycles, then timeout pulse and 1 IDLE cycle; then grant[31] for 4 cycles, timeout pulse and IDLE; then grant[0] again.
REQ-030 Fairness test: after requester 4 releases (ptr=5), apply req=32'h0000_0088 -> grant_idx=7, not 3.
REQ-031 Reset mid-grant test: assert rst_n=0 during the 3rd GRANT cycle for requester 9 -> next cycle grant=0 and timeout=0; after reset, req[9]=1 -> requester 9 is granted again.
REQ-032 Simultaneous-event test: MAX_HOLD=4, drop req[idx] on the cycle hold_cnt=3 -> voluntary release with timeout=0.

Source files
------------

// File: rtl/lab3_arb_pkg.sv
// rtl/lab3_arb_pkg.sv - shared constants, FSM encoding and search helper for the round-robin arbiter
package lab3_arb_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Rotating priority search: walk from the highest offset down so the
    // lowest offset from ptr that has a request is the last one written.
    function automatic logic [IDX_W-1:0] first_req(input logic [N_REQ-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        first_req = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                first_req = cand;
            end
        end
    endfunction

endpackage

// File: rtl/lab3_rr_arbiter_32_if.sv
// rtl/lab3_rr_arbiter_32_if.sv - request/grant bus between requesters and the arbiter
interface lab3_rr_arbiter_32_if;
    import lab3_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_vld,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_vld,
        output timeout
    );

endinterface

// File: rtl/Lab2_decoder_5x32.sv
// rtl/Lab2_decoder_5x32.sv - 5-to-32 one-hot decoder with enable
module Lab2_decoder_5x32 (
    output logic [31:0] Dout,
    input  logic [4:0]  A,
    input  logic        enable
);

    assign Dout = enable ? (32'd1 << A) : 32'd0;

endmodule

// File: rtl/lab3_rr_arbiter_32.sv
// rtl/lab3_rr_arbiter_32.sv - 32-way round-robin arbiter with bounded grant hold and forced-release pulse
module lab3_rr_arbiter_32
    import lab3_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lab3_rr_arbiter_32_if.slave     bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             vld_q, vld_d;
    logic             tmo_q, tmo_d;
    logic [N_REQ-1:0] grant_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
        end
    end

    // A dropped request wins over the hold limit, so timeout only fires
    // when the grantee is still asking at the last permitted cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    idx_d   = first_req(bus.req, ptr_q);
                    vld_d   = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q] || hold_q == HOLD_LAST) begin
                    tmo_d   = bus.req[idx_q];
                    vld_d   = 1'b0;
                    hold_d  = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    Lab2_decoder_5x32 u_dec (
        .Dout   (grant_dec),
        .A      (idx_q),
        .enable (vld_q)
    );

    assign bus.grant     = grant_dec;
    assign bus.grant_idx = idx_q;
    assign bus.grant_vld = vld_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_lab3_rr_arbiter_32.sv
// tb/tb_lab3_rr_arbiter_32.sv - table, directed and randomized checks of the round-robin arbiter
module tb_lab3_rr_arbiter_32;

    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    lab3_rr_arbiter_32_if bus ();

    lab3_rr_arbiter_32 #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic [31:0] req;
        int          reps;
        logic [31:0] eg;
        logic [4:0]  ei;
        logic        ev;
        logic        et;
    } vec_t;

    vec_t tbl [20];

    // Reference: owner is granted for m_held cycles so far; release after HOLD cycles.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_tmo;

    function automatic logic [31:0] m_grant();
        return m_busy ? (32'd1 << m_owner) : 32'd0;
    endfunction

    task automatic model_edge(input logic rn, input logic [31:0] r);
        if (!rn) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
        end else if (!m_busy) begin
            m_tmo = 0;
            if (r != 0) begin
                for (int k = 0; k < 32; k++) begin
                    if (r[(m_ptr + k) % 32]) begin
                        m_owner = (m_ptr + k) % 32;
                        break;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            m_tmo = 0;
            if (!r[m_owner] || m_held == HOLD) begin
                m_tmo  = r[m_owner];
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 32;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step(input logic rn, input logic [31:0] r);
        @(negedge clk);
        rst_n   = rn;
        bus.req = r;
        @(posedge clk);
        model_edge(rn, r);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] eg, input logic [4:0] ei,
                         input logic ev, input logic et);
        n_vec++;
        if (bus.grant !== eg || bus.grant_idx !== ei || bus.grant_vld !== ev || bus.timeout !== et) begin
            n_bad++;
            $display("FAIL %s: got grant=%h idx=%0d vld=%b tmo=%b, expected grant=%h idx=%0d vld=%b tmo=%b",
                     name, bus.grant, bus.grant_idx, bus.grant_vld, bus.timeout, eg, ei, ev, et);
        end
    endtask

    initial begin
        logic [31:0] rq;
        logic        rn;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req = '0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tmo = 0;

        tbl[0]  = '{1'b0, 32'h0,          2,  32'h0,          5'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0,          50, 32'h0,          5'd0,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0001,  1,  32'h0000_0001,  5'd0,  1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h0,          1,  32'h0,          5'd0,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,          1,  32'h0,          5'd0,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h8000_0001,  4,  32'h0000_0001,  5'd0,  1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h8000_0001,  1,  32'h0,          5'd0,  1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h8000_0001,  4,  32'h8000_0000,  5'd31, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h8000_0001,  1,  32'h0,          5'd31, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 32'h8000_0001,  1,  32'h0000_0001,  5'd0,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'h0,          1,  32'h0,          5'd0,  1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0010,  1,  32'h0000_0010,  5'd4,  1'b1, 1'b0};
        tbl[12] = '{1'b1, 32'h0,          1,  32'h0,          5'd4,  1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'h0000_0088,  1,  32'h0000_0080,  5'd7,  1'b1, 1'b0};
        tbl[14] = '{1'b1, 32'h0,          1,  32'h0,          5'd7,  1'b0, 1'b0};
        tbl[15] = '{1'b1, 32'h0000_0100,  1,  32'h0000_0100,  5'd8,  1'b1, 1'b0};
        tbl[16] = '{1'b1, 32'h0000_0101,  1,  32'h0000_0100,  5'd8,  1'b1, 1'b0};
        tbl[17] = '{1'b1, 32'h0000_0001,  1,  32'h0,          5'd8,  1'b0, 1'b0};
        tbl[18] = '{1'b1, 32'h0000_0001,  1,  32'h0000_0001,  5'd0,  1'b1, 1'b0};
        tbl[19] = '{1'b1, 32'h0,          1,  32'h0,          5'd0,  1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].rn, tbl[i].req);
                check($sformatf("vec%0d.%0d", i, r), tbl[i].eg, tbl[i].ei, tbl[i].ev, tbl[i].et);
            end
        end

        // Reset during the third grant cycle of requester 9.
        for (int c = 1; c <= 3; c++) begin
            step(1'b1, 32'h0000_0200);
            check($sformatf("rst_mid.grant%0d", c), 32'h0000_0200, 5'd9, 1'b1, 1'b0);
        end
        step(1'b0, 32'h0000_0200);
        check("rst_mid.reset", 32'h0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0200);
        check("rst_mid.regrant", 32'h0000_0200, 5'd9, 1'b1, 1'b0);
        step(1'b1, 32'h0);
        check("rst_mid.release", 32'h0, 5'd9, 1'b0, 1'b0);

        // Request drops on the very edge the hold limit is reached.
        for (int c = 1; c <= HOLD; c++) begin
            step(1'b1, 32'h0000_1000);
            check($sformatf("simul.grant%0d", c), 32'h0000_1000, 5'd12, 1'b1, 1'b0);
        end
        step(1'b1, 32'h0);
        check("simul.release", 32'h0, 5'd12, 1'b0, 1'b0);
        step(1'b1, 32'h0);
        check("simul.idle", 32'h0, 5'd12, 1'b0, 1'b0);

        rq = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0:       rq = '0;
                    1:       rq = 32'd1 << $urandom_range(31);
                    2:       rq = $urandom & $urandom & $urandom;
                    default: rq = $urandom;
                endcase
            end
            rn = ($urandom_range(59) != 0);
            step(rn, rq);
            check($sformatf("rand%0d", c), m_grant(), 5'(m_owner), m_busy, m_tmo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
